// File: rtl/seq_detect_pkg.sv
// Shared definitions for the sequence-detector controller slice.
// Contents:
//   MAX_LEN_DEF / CNT_W_DEF - default pattern length limit and counter width
//   state_t                 - controller states (IDLE, RUN, DONE)
//   calc_len_w()            - width needed to encode a length of 0..max_len
package seq_detect_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One extra bit beyond $clog2 so that MAX_LEN itself (and MAX_LEN+1 for
  // rejection) is representable.
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration channel of the sequence-detector controller.
//
// Handshake: a configuration transfers on a rising clk edge where both
// cfg_valid and cfg_ready are high. The master holds cfg_pattern, cfg_len,
// cfg_overlap and cfg_target stable while cfg_valid is high; cfg_ready does
// not depend on cfg_valid. A transferred config with an illegal length is
// dropped and answered with a one-cycle cfg_err pulse after that edge.
//
// Signals:
//   cfg_valid   master->slave  configuration offer
//   cfg_ready   slave->master  slave can accept (controller idle)
//   cfg_pattern master->slave  pattern, bit [cfg_len-1] received first
//   cfg_len     master->slave  pattern length, legal 1..MAX_LEN
//   cfg_overlap master->slave  1 = overlapping matches allowed
//   cfg_target  master->slave  matches per session, 0 = unlimited
//   cfg_err     slave->master  one-cycle pulse on a rejected config
interface seq_detect_ctrl_if
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int LEN_W   = calc_len_w(MAX_LEN)
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               cfg_err;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/seq_match_core.sv
// Bit-serial pattern matcher: history shift register, saturating fill
// counter and a length-masked compare against the programmed pattern.
//
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   shift_en       accept x this cycle (qualified bit in an active session)
//   x              serial data bit, newest bit enters at hist[0]
//   clear          start of session: empty the history
//   keep_on_match  1 = history survives a match (overlap mode)
//   pattern, len   programmed pattern and its length (1..MAX_LEN)
//   hit            combinational: the bit being shifted in completes a match
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               x,
  input  logic               clear,
  input  logic               keep_on_match,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W:0]     fill_inc;
  logic               fill_ok;

  always_comb begin
    hist_next = {hist[MAX_LEN-2:0], x};
    fill_inc  = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    // Enough bits seen once this one is counted.
    fill_ok   = (fill_inc >= {1'b0, len});
    mask      = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = shift_en && fill_ok && (((hist_next ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      if (hit && !keep_on_match) begin
        // Non-overlap: the next match must be built from fresh bits only.
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= hist_next;
        fill <= fill_ok ? len : fill_inc[LEN_W-1:0];
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Session controller around seq_match_core: accepts a pattern config over
// the cfg interface, runs detection sessions, counts matches and ends a
// session on reaching the target count or on abort.
//
// Ports:
//   clk, rst    clock, synchronous active-low reset
//   cfg         configuration channel (slave side)
//   start       start a session (from IDLE with a valid config, or DONE)
//   abort       end the session, return to IDLE; beats start and a match
//   x, x_valid  serial data bit and its qualifier
//   y           registered match pulse, high the cycle after a counted match
//   match_cnt   matches in the current or last session
//   busy, done  decoded from state: RUN, DONE
//   dbg_state   current controller state
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  seq_detect_ctrl_if.slave  cfg,
  input  logic              start,
  input  logic              abort,
  input  logic              x,
  input  logic              x_valid,
  output logic              y,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);

  state_t             state;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               overlap_r;
  logic [CNT_W-1:0]   target_r;
  logic               cfg_ok;
  logic               cfg_err_r;

  logic               launch;
  logic               shift_en;
  logic               hit;
  logic               len_legal;
  logic [CNT_W-1:0]   cnt_inc;

  assign busy          = (state == ST_RUN);
  assign done          = (state == ST_DONE);
  assign dbg_state     = state;
  assign cfg.cfg_ready = (state == ST_IDLE);
  assign cfg.cfg_err   = cfg_err_r;

  always_comb begin
    // A fresh session begins from IDLE (needs a stored config) or from DONE.
    launch    = start && !abort &&
                (((state == ST_IDLE) && cfg_ok) || (state == ST_DONE));
    shift_en  = (state == ST_RUN) && x_valid;
    len_legal = (cfg.cfg_len != '0) && (cfg.cfg_len <= LEN_W'(MAX_LEN));
    cnt_inc   = match_cnt + CNT_W'(1);
  end

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk           (clk),
    .rst           (rst),
    .shift_en      (shift_en),
    .x             (x),
    .clear         (launch),
    .keep_on_match (overlap_r),
    .pattern       (pat_r),
    .len           (len_r),
    .hit           (hit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      y         <= 1'b0;
      match_cnt <= '0;
      cfg_err_r <= 1'b0;
      pat_r     <= '0;
      len_r     <= '0;
      overlap_r <= 1'b0;
      target_r  <= '0;
      cfg_ok    <= 1'b0;
    end else begin
      y         <= 1'b0;
      cfg_err_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg.cfg_valid) begin
            if (len_legal) begin
              pat_r     <= cfg.cfg_pattern;
              len_r     <= cfg.cfg_len;
              overlap_r <= cfg.cfg_overlap;
              target_r  <= cfg.cfg_target;
              cfg_ok    <= 1'b1;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end
          if (launch) begin
            state     <= ST_RUN;
            match_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (hit) begin
            y <= 1'b1;
            if (target_r == '0) begin
              if (match_cnt != {CNT_W{1'b1}}) match_cnt <= cnt_inc;
            end else begin
              match_cnt <= cnt_inc;
              if (cnt_inc == target_r) state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (launch) begin
            state     <= ST_RUN;
            match_cnt <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;
  import seq_detect_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             x = 1'b0;
  logic             x_valid = 1'b0;
  logic             y;
  logic [CNT_W-1:0] match_cnt;
  logic             busy;
  logic             done;
  state_t           dbg_state;

  seq_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) cfg_if ();

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg_if.slave),
    .start     (start),
    .abort     (abort),
    .x         (x),
    .x_valid   (x_valid),
    .y         (y),
    .match_cnt (match_cnt),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [CNT_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor: every y pulse must correspond to a queued expected match and
  // carry the expected running count.
  always @(negedge clk) begin
    if (rst && y) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL y_unexpected: actual=y_pulse cnt=%0d expected=no_pulse", match_cnt);
      end else begin
        logic [CNT_W-1:0] e;
        e = exp_q.pop_front();
        if (match_cnt != e) begin
          failures++;
          $display("FAIL y_count: actual=%0d expected=%0d", match_cnt, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic configure(input logic [7:0] pat, input logic [LEN_W-1:0] len,
                           input logic ov, input logic [CNT_W-1:0] tgt,
                           input logic exp_err);
    int waited;
    cfg_if.cfg_pattern = pat;
    cfg_if.cfg_len     = len;
    cfg_if.cfg_overlap = ov;
    cfg_if.cfg_target  = tgt;
    cfg_if.cfg_valid   = 1'b1;
    waited = 0;
    while (!cfg_if.cfg_ready && waited < 8) begin
      tick();
      waited++;
    end
    if (!cfg_if.cfg_ready) begin
      checks++;
      failures++;
      $display("FAIL cfg_ready_timeout: actual=0 expected=1");
    end
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("cfg_err", int'(cfg_if.cfg_err), int'(exp_err));
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic v, input logic m,
                          input logic [CNT_W-1:0] c);
    x = b;
    x_valid = v;
    if (m) exp_q.push_back(c);
    tick();
    x_valid = 1'b0;
    x = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic check_drained(input string name);
    tick();
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_pattern = '0;
    cfg_if.cfg_len     = '0;
    cfg_if.cfg_overlap = 1'b0;
    cfg_if.cfg_target  = '0;
    tick();
    do_reset();

    // Reset state
    check("rst_y", int'(y), 0);
    check("rst_cnt", int'(match_cnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(cfg_if.cfg_ready), 1);
    check("rst_err", int'(cfg_if.cfg_err), 0);

    // Illegal length from reset: error pulse, start ignored
    configure(8'h06, 4'd0, 1'b0, 8'd2, 1'b1);
    start_session();
    check("err_one_cycle", int'(cfg_if.cfg_err), 0);
    check("nocfg_busy", int'(busy), 0);
    check("nocfg_state", int'(dbg_state), int'(ST_IDLE));

    // Pattern 110, non-overlap, target 2
    configure(8'h06, 4'd3, 1'b0, 8'd2, 1'b0);
    start_session();
    check("p110_busy", int'(busy), 1);
    send_bit(1, 1, 0, 0);
    send_bit(1, 1, 0, 0);
    send_bit(0, 1, 1, 1);
    check("p110_mid_busy", int'(busy), 1);
    send_bit(1, 1, 0, 0);
    send_bit(1, 1, 0, 0);
    send_bit(0, 1, 1, 2);
    check("p110_done", int'(done), 1);
    check("p110_busy_end", int'(busy), 0);
    check("p110_cnt", int'(match_cnt), 2);
    check_drained("p110_drain");
    check("p110_done_hold", int'(match_cnt), 2);
    do_abort();
    check("p110_idle", int'(cfg_if.cfg_ready), 1);

    // Pattern 101 overlap, unlimited target
    configure(8'h05, 4'd3, 1'b1, 8'd0, 1'b0);
    start_session();
    send_bit(1, 1, 0, 0);
    send_bit(0, 1, 0, 0);
    send_bit(1, 1, 1, 1);
    send_bit(0, 1, 0, 0);
    send_bit(1, 1, 1, 2);
    check_drained("p101ov_drain");
    check("p101ov_cnt", int'(match_cnt), 2);
    check("p101ov_busy", int'(busy), 1);
    do_abort();
    check("p101ov_cnt_held", int'(match_cnt), 2);

    // Pattern 101 non-overlap
    configure(8'h05, 4'd3, 1'b0, 8'd0, 1'b0);
    start_session();
    send_bit(1, 1, 0, 0);
    send_bit(0, 1, 0, 0);
    send_bit(1, 1, 1, 1);
    send_bit(0, 1, 0, 0);
    send_bit(1, 1, 0, 0);
    check_drained("p101nov_drain");
    check("p101nov_cnt", int'(match_cnt), 1);
    do_abort();

    // Valid 110, then an over-long config is rejected and the old one kept;
    // gaps in x_valid carry x=0 that must be ignored.
    configure(8'h06, 4'd3, 1'b0, 8'd0, 1'b0);
    configure(8'hFF, 4'd9, 1'b1, 8'd1, 1'b1);
    start_session();
    send_bit(1, 1, 0, 0);
    send_bit(0, 0, 0, 0);
    send_bit(1, 1, 0, 0);
    send_bit(0, 0, 0, 0);
    send_bit(0, 1, 1, 1);
    check_drained("gap_drain");
    check("gap_cnt", int'(match_cnt), 1);
    do_abort();

    // Full-length pattern A5, target 1; then restart from DONE
    configure(8'hA5, 4'd8, 1'b0, 8'd1, 1'b0);
    start_session();
    send_bit(1, 1, 0, 0);
    send_bit(0, 1, 0, 0);
    send_bit(1, 1, 0, 0);
    send_bit(0, 1, 0, 0);
    send_bit(0, 1, 0, 0);
    send_bit(1, 1, 0, 0);
    send_bit(0, 1, 0, 0);
    send_bit(1, 1, 1, 1);
    check("a5_done", int'(done), 1);
    check_drained("a5_drain");
    start_session();
    check("a5_restart_busy", int'(busy), 1);
    check("a5_restart_cnt", int'(match_cnt), 0);
    do_abort();

    // Abort on the edge that would complete match 2
    configure(8'h06, 4'd3, 1'b0, 8'd3, 1'b0);
    start_session();
    send_bit(1, 1, 0, 0);
    send_bit(1, 1, 0, 0);
    send_bit(0, 1, 1, 1);
    send_bit(1, 1, 0, 0);
    send_bit(1, 1, 0, 0);
    abort = 1'b1;
    send_bit(0, 1, 0, 0);
    abort = 1'b0;
    check("abort_ready", int'(cfg_if.cfg_ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_cnt", int'(match_cnt), 1);
    check_drained("abort_drain");
    start_session();
    check("abort_restart_cnt", int'(match_cnt), 0);
    check("abort_restart_busy", int'(busy), 1);

    // Reset mid-session
    send_bit(1, 1, 0, 0);
    send_bit(1, 1, 0, 0);
    do_reset();
    check("mrst_y", int'(y), 0);
    check("mrst_cnt", int'(match_cnt), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_ready", int'(cfg_if.cfg_ready), 1);
    start_session();
    check("mrst_start_ignored", int'(busy), 0);
    check_drained("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Programmable serial sequence-detector controller. Accepts a pattern configuration of 1..MAX_LEN bits through a valid/ready handshake. Runs a detection session on a qualified bit stream and counts matches, with overlap or non-overlap mode. Ends the session after a target match count or on abort. It is the control/sequencing layer around a Moore-style bit-serial pattern matcher and replaces fixed-pattern detectors (e.g. "110") with one configurable, session-managed block.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter and target
LEN_W, $clog2(MAX_LEN)+1, width of cfg_len (derived; do not override)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-low reset; sampled on posedge clk
cfg_valid  in  1  configuration offer
cfg_ready  out  1  high only in IDLE
cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit 0 the last
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping matches allowed
cfg_target  in  CNT_W  matches per session; 0 = unlimited
cfg_err  out  1  one-cycle pulse when an offered config is rejected
start  in  1  start session (level sampled per cycle)
abort  in  1  terminate session
x  in  1  serial data bit
x_valid  in  1  x qualifier
y  out  1  registered match pulse
match_cnt  out  CNT_W  matches in current or last session
busy  out  1  high in RUN
done  out  1  high in DONE

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, y=0, match_cnt=0, busy=0, done=0, cfg_err=0, stored config cleared, cfg_ok=0. Reset mid-session discards everything.
- States: IDLE, RUN, DONE. busy and done are decoded from registered state. cfg_ready = (state==IDLE).
- IDLE, config handshake: cfg_valid&&cfg_ready at an edge.
  - cfg_len in 1..MAX_LEN: latch pattern, len, overlap and target; set cfg_ok.
  - cfg_len=0 or >MAX_LEN: keep the previous config and pulse cfg_err for one cycle.
- IDLE -> RUN: start=1 && cfg_ok && !abort. On entry, clear history, fill counter, match_cnt and y. If cfg_ok=0, start is ignored.
- RUN, on an edge with x_valid=1:
  - hist <= {hist[MAX_LEN-2:0], x}.
  - fill <= min(fill+1, len).
  - A match occurs when (fill+1)>=len and the low len bits of the new hist equal the low len bits of pattern.
- RUN, cycles with x_valid=0: no history change and no match.
- On a match at edge k:
  - y=1 for exactly the cycle following edge k.
  - match_cnt increments at edge k, saturating at all-ones when target=0.
  - Non-overlap mode: fill and history reset to 0, so the next match needs len fresh bits.
  - Overlap mode: history kept.
- RUN -> DONE: at the edge where the increment makes match_cnt==cfg_target (target!=0); y pulses in the same cycle done rises.
- RUN -> IDLE: abort=1. Abort has priority over a same-edge match: no y, no count. match_cnt is held.
- start during RUN is ignored; cfg_valid outside IDLE gets no ready.
- DONE: holds match_cnt.
  - start=1 -> RUN with a fresh session (same config).
  - abort=1 -> IDLE; abort wins over start.
- y is 0 in every cycle not directly following a counted match.

Decomposition:
- Package seq_detect_pkg:
  - state enum (IDLE, RUN, DONE)
  - MAX_LEN default
  - LEN_W derivation helper
- Sub-module seq_match_core: history shift register, saturating fill counter, masked compare. It has inputs shift_en, x, clear, keep_on_match, pattern and len, and a combinational output hit. The controller owns the FSM, counter, handshake and y register.

Test Plan:
- Pattern 110 (cfg_pattern=8'h06, len=3, overlap=0, target=2); x=1,1,0,1,1,0 all valid -> y pulses after the 3rd and 6th bits; match_cnt=2; done=1 after the 6th bit; busy=0.
- Pattern 101, len=3, target=0; x=1,0,1,0,1 -> overlap=1 gives 2 y pulses and match_cnt=2; overlap=0 gives 1 pulse and match_cnt=1.
- cfg_len=0 offered from reset -> cfg_err one-cycle pulse, cfg_ok stays 0; start=1 -> state stays IDLE, busy=0.
- Pattern 110, x_valid toggling 1,0,1,0,1 with x=1,-,1,-,0 -> a single match; y high exactly one cycle after the final valid bit.
- RUN with target=3 after 1 match; abort asserted on the edge that would complete match 2 -> y stays 0, match_cnt=1, state IDLE; then start -> match_cnt=0.
- rst=0 for one cycle mid-RUN -> next cycle y=0, match_cnt=0, busy=0, done=0, cfg_ready=1; start without reconfiguration is ignored.
